// File: rtl/fp_pkg.sv
// Shared width helpers for the fixed-point adder.
package fp_pkg;

  function automatic int max2(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  function automatic int max3(input int x, input int y, input int z);
    return max2(max2(x, y), z);
  endfunction

  // Fraction bits of the common aligned format.
  function automatic int frac_width(input int f1, input int f2, input int f3);
    return max3(f1, f2, f3);
  endfunction

  // Integer bits of the aligned sum. This covers both operands plus two guard bits.
  // i3 is also included so the output limits always fit the word when i3 > max(i1,i2).
  function automatic int int_width(input int i1, input int i2, input int i3);
    return max3(i1, i2, i3) + 2;
  endfunction

  function automatic int sum_width(input int i1, input int f1, input int i2,
                                   input int f2, input int i3, input int f3);
    return int_width(i1, i2, i3) + frac_width(f1, f2, f3);
  endfunction

endpackage

// File: rtl/fp_sat.sv
// Saturates an aligned signed sum into Q(i3.f3) and flags out-of-range results.
module fp_sat
  import fp_pkg::*;
#(
  parameter int i3    = 2,
  parameter int f3    = 14,
  parameter int frac  = 14,
  parameter int width = 18
) (
  input  logic signed [width-1:0] sum,
  input  logic                    sign,
  output logic [i3+f3-1:0]        c,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int SHIFT = frac - f3;
  localparam logic signed [width-1:0] ONE  = width'(1);
  localparam logic signed [width-1:0] ZERO = '0;
  // Format limits expressed in the aligned (frac fraction bits) domain.
  localparam logic signed [width-1:0] UMAX = ((ONE <<< (i3 + f3)) - ONE) <<< SHIFT;
  localparam logic signed [width-1:0] SMAX = ((ONE <<< (i3 + f3 - 1)) - ONE) <<< SHIFT;
  localparam logic signed [width-1:0] SMIN = ZERO - (ONE <<< (i3 + frac - 1));

  logic [i3+f3-1:0] in_range;

  // Dropping the LSBs of a two's complement word rounds toward negative infinity.
  assign in_range = sum[SHIFT +: i3+f3];

  // Compare the exact sum against the selected format limits and clamp.
  always_comb begin
    c         = in_range;
    overflow  = 1'b0;
    underflow = 1'b0;
    if (sign) begin
      if (sum > SMAX) begin
        c        = {1'b0, {(i3+f3-1){1'b1}}};
        overflow = 1'b1;
      end else if (sum < SMIN) begin
        c         = {1'b1, {(i3+f3-1){1'b0}}};
        underflow = 1'b1;
      end
    end else begin
      if (sum > UMAX) begin
        c        = '1;
        overflow = 1'b1;
      end else if (sum < ZERO) begin
        c         = '0;
        underflow = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_add.sv
// Registered fixed-point adder: Q(i1.f1) + Q(i2.f2) -> saturated Q(i3.f3).
module fp_add
  import fp_pkg::*;
#(
  parameter int i1 = 2,
  parameter int f1 = 14,
  parameter int i2 = 2,
  parameter int f2 = 14,
  parameter int i3 = 2,
  parameter int f3 = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [i1+f1-1:0] a,
  input  logic             s1,
  input  logic [i2+f2-1:0] b,
  input  logic             s2,
  output logic             out_valid,
  output logic [i3+f3-1:0] c,
  output logic             sign,
  output logic             overflow,
  output logic             underflow
);

  localparam int F = frac_width(f1, f2, f3);
  localparam int W = sum_width(i1, f1, i2, f2, i3, f3);

  logic signed [W-1:0] a_ext, b_ext, sum;
  logic [i3+f3-1:0]    c_sat;
  logic                sign_sel, ovf_sat, unf_sat;

  // Extend each operand by its own signedness, then zero-fill the fraction to F bits.
  always_comb begin
    if (s1) a_ext = W'($signed(a));
    else    a_ext = W'($unsigned(a));
    if (s2) b_ext = W'($signed(b));
    else    b_ext = W'($unsigned(b));
    a_ext    = a_ext <<< (F - f1);
    b_ext    = b_ext <<< (F - f2);
    sum      = a_ext + b_ext;
    sign_sel = s1 | s2;
  end

  fp_sat #(
    .i3   (i3),
    .f3   (f3),
    .frac (F),
    .width(W)
  ) u_sat (
    .sum      (sum),
    .sign     (sign_sel),
    .c        (c_sat),
    .overflow (ovf_sat),
    .underflow(unf_sat)
  );

  // Output register: capture on in_valid, otherwise hold results and drop out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      c         <= '0;
      sign      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        c         <= c_sat;
        sign      <= sign_sel;
        overflow  <= ovf_sat;
        underflow <= unf_sat;
      end
    end
  end

endmodule

// File: tb/tb_fp_add.sv
// Directed bench for fp_add with default Q2.14 formats.
module tb_fp_add;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] a, b;
  logic        s1, s2;
  logic        out_valid;
  logic [15:0] c;
  logic        sign, overflow, underflow;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic        s1;
    logic [15:0] b;
    logic        s2;
    logic [15:0] c;
    logic        sign;
    logic        ovf;
    logic        unf;
  } vec_t;

  vec_t vecs [$];

  fp_add #(
    .i1(2), .f1(14), .i2(2), .f2(14), .i3(2), .f3(14)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .a        (a),
    .s1       (s1),
    .b        (b),
    .s2       (s2),
    .out_valid(out_valid),
    .c        (c),
    .sign     (sign),
    .overflow (overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string name, input logic vld, input logic [15:0] ec,
                               input logic es, input logic eo, input logic eu);
    check({name, ".out_valid"}, 32'(out_valid), 32'(vld));
    check({name, ".c"},         32'(c),         32'(ec));
    check({name, ".sign"},      32'(sign),      32'(es));
    check({name, ".overflow"},  32'(overflow),  32'(eo));
    check({name, ".underflow"}, 32'(underflow), 32'(eu));
  endtask

  initial begin
    //            name        a        s1    b        s2    c        sign  ovf   unf
    vecs.push_back('{"u_add",   16'h6000, 1'b0, 16'h8000, 1'b0, 16'hE000, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{"u_ovf",   16'hC000, 1'b0, 16'h8000, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{"mixed",   16'hC000, 1'b1, 16'h2000, 1'b0, 16'hE000, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{"s_unf",   16'h8000, 1'b1, 16'hC000, 1'b1, 16'h8000, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{"s_ovf",   16'h6000, 1'b1, 16'h4000, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{"s_max",   16'h7FFF, 1'b1, 16'h0000, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{"s_min",   16'h8000, 1'b1, 16'h0000, 1'b1, 16'h8000, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{"u_max",   16'hFFFF, 1'b0, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{"mix_ovf", 16'hC000, 1'b0, 16'h4000, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{"mix_neg", 16'h0000, 1'b0, 16'hC000, 1'b1, 16'hC000, 1'b1, 1'b0, 1'b0});

    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    s1       = 1'b0;
    s2       = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_outputs("reset", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

    @(negedge clk) rst = 1'b0;

    // Back-to-back operands: in_valid stays high across the whole table.
    foreach (vecs[i]) begin
      @(negedge clk);
      a        = vecs[i].a;
      s1       = vecs[i].s1;
      b        = vecs[i].b;
      s2       = vecs[i].s2;
      in_valid = 1'b1;
      @(posedge clk);
      #1 check_outputs(vecs[i].name, 1'b1, vecs[i].c, vecs[i].sign, vecs[i].ovf, vecs[i].unf);
    end

    // Idle cycles: results hold, out_valid low, even with new operand values.
    @(negedge clk);
    in_valid = 1'b0;
    a        = 16'h1234;
    b        = 16'h4321;
    repeat (2) begin
      @(posedge clk);
      #1 check_outputs("hold", 1'b0, 16'hC000, 1'b1, 1'b0, 1'b0);
    end

    // Reset in the cycle after an accepted operand discards the in-flight operation.
    @(negedge clk);
    a        = 16'hC000;
    s1       = 1'b0;
    b        = 16'h8000;
    s2       = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 check_outputs("pre_rst", 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    a   = 16'h6000;
    @(posedge clk);
    #1 check_outputs("rst_prio", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1 check_outputs("post_rst", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_add.md
Name: fp_add

Overview:
- Registered fixed-point adder. Operand a is Q(i1.f1) and operand b is Q(i2.f2); each operand carries its own signedness select.
- Produces a saturated Q(i3.f3) sum with a signedness flag and overflow/underflow flags.
- Used as the add stage of fixed-point datapaths where operand and result formats differ by parameter.

Parameters:
- i1, 2, integer bits of a (includes sign bit when a is signed)
- f1, 14, fractional bits of a
- i2, 2, integer bits of b
- f2, 14, fractional bits of b
- i3, 2, integer bits of c
- f3, 14, fractional bits of c

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  a/b/s1/s2 are sampled this cycle
- a  in  i1+f1  operand A bit pattern
- s1  in  1  1: a is two's complement; 0: a is unsigned
- b  in  i2+f2  operand B bit pattern
- s2  in  1  1: b is two's complement; 0: b is unsigned
- out_valid  out  1  c/sign/overflow/underflow hold a new result
- c  out  i3+f3  sum in Q(i3.f3)
- sign  out  1  1: c is two's complement; 0: c is unsigned
- overflow  out  1  exact sum exceeded the maximum of the output format
- underflow  out  1  exact sum was below the minimum of the output format

Behaviour:
- One clock, synchronous active-high reset rst. Every output is registered.
- Reset: c=0, sign=0, overflow=0, underflow=0, out_valid=0. Reset has priority over in_valid; an operation in flight when rst is asserted is discarded.
- Latency is 1 cycle. When in_valid=1 at edge N, the result is visible after edge N and out_valid=1 for that one cycle.
- When in_valid=0, out_valid drops to 0 and c/sign/flags hold their last values. There is no backpressure; a new operand may be accepted every cycle.
- Alignment: extend each operand to a common format with F = max(f1,f2,f3) fractional bits, zero-filling on the right. Use sign extension when s=1 and zero extension when s=0. The integer width is max(i1,i2)+2 so the exact sum can never wrap.
- Exact sum: sum = A_ext + B_ext. This is a signed internal word.
- Output signedness: sign = s1 | s2.
- Output range, unsigned (sign=0): [0, 2^i3 - 2^-f3]. Signed (sign=1): [-2^(i3-1), 2^(i3-1) - 2^-f3].
- Fraction reduction: when F > f3, truncate toward negative infinity by dropping the LSBs.
- Saturation:
  - If the sum is greater than the format max: c = max pattern (unsigned all ones; signed 0111..1), overflow=1.
  - If the sum is less than the format min: c = min pattern (signed 1000..0; unsigned 0), underflow=1.
  - Otherwise c = the in-range value, and both flags are 0.
- overflow and underflow are never both 1. Both are evaluated on the exact sum before truncation.
- A result exactly equal to max or min is in range and raises no flag.
- Unsigned + unsigned can only overflow, never underflow.
- Parameters of any width must elaborate correctly, including f3 > max(f1,f2) (zero-fill) and i3 < max(i1,i2).

Decomposition:
- Shared package fp_pkg: localparam helpers max2/max3, and a function computing the common internal width.
- One natural sub-module fp_sat. It is combinational, maps the aligned signed sum plus the sign select to the Q(i3.f3) pattern, and produces the overflow/underflow flags.
- fp_add contains the alignment/extension logic, the adder, and the output register stage.

Test Plan:
- Unsigned add, default params: a=0x6000 (1.5), s1=0; b=0x8000 (2.0), s2=0 -> next cycle c=0xE000 (3.5), sign=0, overflow=0, underflow=0, out_valid=1.
- Unsigned overflow: a=0xC000 (3.0), b=0x8000 (2.0), s1=s2=0 -> c=0xFFFF, overflow=1, underflow=0, sign=0.
- Mixed sign: a=0xC000 with s1=1 (-1.0); b=0x2000 with s2=0 (0.5) -> c=0xE000 (-0.5), sign=1, no flags.
- Signed underflow: a=0x8000 (-2.0) and b=0xC000 (-1.0), s1=s2=1 -> c=0x8000, underflow=1, overflow=0.
- Signed overflow: a=0x6000 (1.5) and b=0x4000 (1.0), s1=s2=1 -> c=0x7FFF, overflow=1. Boundary case: a=0x7FFF, b=0x0000 -> c=0x7FFF with no flag.
- Control: issue back-to-back in_valid pulses, then assert rst in the cycle after an in_valid -> outputs all 0 and out_valid=0 on the next edge. With in_valid=0 the outputs hold their values.
